// File: rtl/poisson_spike_encoder_pkg.sv
// rtl/poisson_spike_encoder_pkg.sv - shared neuron constants and encoder FSM encoding
package poisson_spike_encoder_pkg;

  localparam int DSIZE_DEF  = 16;
  localparam int NUM_CH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  function automatic int ch_aw(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/poisson_spike_encoder_if.sv
// rtl/poisson_spike_encoder_if.sv - encoder bus: start, rate memory, LFSR and spike output
interface poisson_spike_encoder_if #(
  parameter int DSIZE  = poisson_spike_encoder_pkg::DSIZE_DEF,
  parameter int NUM_CH = poisson_spike_encoder_pkg::NUM_CH_DEF,
  parameter int CH_AW  = poisson_spike_encoder_pkg::ch_aw(NUM_CH)
);

  logic              start_i;
  logic [CH_AW-1:0]  rate_addr_o;
  logic [DSIZE-1:0]  rate_i;
  logic              rd_rand_o;
  logic [DSIZE-1:0]  rand_dat_i;
  logic [NUM_CH-1:0] spike_o;
  logic              spike_vld_o;
  logic              busy_o;

  modport master (
    input  start_i, rate_i, rand_dat_i,
    output rate_addr_o, rd_rand_o, spike_o, spike_vld_o, busy_o
  );

  modport slave (
    output start_i, rate_i, rand_dat_i,
    input  rate_addr_o, rd_rand_o, spike_o, spike_vld_o, busy_o
  );

endinterface

// File: rtl/poisson_spike_encoder.sv
// rtl/poisson_spike_encoder.sv - rate-coded Poisson spike encoder, one LFSR word per channel
// Optional one-frame refractory masking when POISSON_REFRACT_EN is defined.
module poisson_spike_encoder
  import poisson_spike_encoder_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_AW  = ch_aw(NUM_CH)
) (
  input logic clk_i,
  input logic rst_i,
  poisson_spike_encoder_if.master enc
);

  localparam logic [CH_AW-1:0] LAST_CH = CH_AW'(NUM_CH - 1);

  enc_state_e        state_q;
  logic [CH_AW-1:0]  ch_q;
  logic [NUM_CH-1:0] work_q, work_d;
  logic [NUM_CH-1:0] spike_q;
  logic              vld_q;
  logic [DSIZE-1:0]  rate_w, rand_w;
  logic              refract;
  logic              hit;

  assign rate_w = enc.rate_i;
  assign rand_w = enc.rand_dat_i;

`ifdef POISSON_REFRACT_EN
  assign refract = spike_q[ch_q];
`else
  assign refract = 1'b0;
`endif

  // A refractory channel still consumes its random word so the LFSR stream is build-independent.
  assign hit = (rate_w > rand_w) && !refract;

  always_comb begin
    work_d       = work_q;
    work_d[ch_q] = hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      work_q  <= '0;
      spike_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enc.start_i) begin
            state_q <= ST_PRIME;
            ch_q    <= '0;
            work_q  <= '0;
          end
        end
        ST_PRIME: state_q <= ST_SCAN;
        ST_SCAN: begin
          work_q <= work_d;
          if (ch_q == LAST_CH) begin
            state_q <= ST_DONE;
            spike_q <= work_d;
            vld_q   <= 1'b1;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Address runs one channel ahead because the rate memory has one cycle of read latency.
  assign enc.rate_addr_o = (state_q == ST_SCAN) ? ch_q + 1'b1 : '0;
  assign enc.rd_rand_o   = (state_q == ST_SCAN);
  assign enc.busy_o      = (state_q != ST_IDLE);
  assign enc.spike_o     = spike_q;
  assign enc.spike_vld_o = vld_q;

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// tb/tb_poisson_spike_encoder.sv - randomized bench with frame-level reference model
module tb_poisson_spike_encoder;

  localparam int N = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  poisson_spike_encoder_if #(.DSIZE(D), .NUM_CH(N), .CH_AW(3)) bus ();

  poisson_spike_encoder #(.DSIZE(D), .NUM_CH(N), .CH_AW(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .enc   (bus)
  );

  logic [D-1:0] rate_mem [N];
  logic [D-1:0] seed = 16'd896;
  logic [D-1:0] lfsr_q;
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], ~(q[15] ^ q[14] ^ q[12] ^ q[3])};
  endfunction

  always @(posedge clk) bus.rate_i <= rate_mem[bus.rate_addr_o];

  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= seed;
    else if (bus.rd_rand_o) lfsr_q <= lfsr_step(lfsr_q);
  end
  assign bus.rand_dat_i = lfsr_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame-level model: a frame accepted at edge t uses the next N LFSR words, busy for N+2 cycles.
  initial begin : compare
    bit in_frame;
    int t0, k, rd_cnt, next_ok;
    logic [N-1:0] pend, exp_spk;
    logic [D-1:0] m_lfsr, w;
    logic s_start, s_rst;
    bit e_rd, e_vld;
    in_frame = 0; t0 = 0; rd_cnt = 0; next_ok = 0;
    pend = '0; exp_spk = '0; m_lfsr = seed;
    forever begin
      @(posedge clk);
      s_start = bus.start_i;
      s_rst   = rst;
      cyc++;
      #1;
      if (s_rst || rst) begin
        in_frame = 0; exp_spk = '0; m_lfsr = seed; rd_cnt = 0; next_ok = 0;
        chk("rst_addr", 32'(bus.rate_addr_o), 32'd0);
      end else if (!in_frame && s_start && cyc >= next_ok) begin
        in_frame = 1; t0 = cyc; rd_cnt = 0; w = m_lfsr;
        for (int j = 0; j < N; j++) begin
          pend[j] = rate_mem[j] > w;
          w = lfsr_step(w);
        end
`ifdef POISSON_REFRACT_EN
        pend = pend & ~exp_spk;
`endif
        m_lfsr = w;
      end
      k = cyc - t0;
      e_rd  = in_frame && k >= 1 && k <= N;
      e_vld = in_frame && k == N + 1;
      if (e_vld) exp_spk = pend;
      if (in_frame && bus.rd_rand_o) rd_cnt++;
      chk("busy", 32'(bus.busy_o), 32'(in_frame));
      chk("rd_rand", 32'(bus.rd_rand_o), 32'(e_rd));
      chk("spike_vld", 32'(bus.spike_vld_o), 32'(e_vld));
      chk("spike", 32'(bus.spike_o), 32'(exp_spk));
      if (in_frame && k < N) chk("rate_addr", 32'(bus.rate_addr_o), 32'(k));
      if (e_vld) begin
        chk("rd_count", 32'(rd_cnt), 32'(N));
        in_frame = 0;
        next_ok  = cyc + 2;
      end
    end
  end

  task automatic set_rates(input int mode);
    for (int j = 0; j < N; j++) begin
      case (mode)
        0: rate_mem[j] = 16'h0000;
        1: rate_mem[j] = 16'hFFFF;
        2: rate_mem[j] = 16'h8000;
        default: begin
          case ($urandom_range(0, 3))
            0: rate_mem[j] = 16'h0000;
            1: rate_mem[j] = 16'hFFFF;
            default: rate_mem[j] = 16'($urandom);
          endcase
        end
      endcase
    end
  endtask

  task automatic do_reset(input logic [D-1:0] s);
    @(negedge clk);
    seed = s;
    rst  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_vld(input string name);
    bit got = 0;
    for (int i = 0; i < 4 * N; i++) begin
      @(negedge clk);
      if (bus.spike_vld_o) begin
        got = 1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_vld("frame_vld");
  endtask

  initial begin : stim
    int last, seen, cnt [N];
    bit got;
    logic [N-1:0] exp_ones;
    bus.start_i = 1'b0;
    set_rates(0);
    #1 rst = 1'b1;
    #1;
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_rd_rand", 32'(bus.rd_rand_o), 32'd0);
    chk("reset_vld", 32'(bus.spike_vld_o), 32'd0);
    chk("reset_spike", 32'(bus.spike_o), 32'd0);
    chk("reset_addr", 32'(bus.rate_addr_o), 32'd0);
    chk("lfsr_pin0", 32'(lfsr_step(16'h0000)), 32'h0001);
    chk("lfsr_pin1", 32'(lfsr_step(16'h0001)), 32'h0003);
    chk("lfsr_pin896", 32'(lfsr_step(16'h0380)), 32'h0701);
    chk("lfsr_lockup", 32'(lfsr_step(16'hFFFF)), 32'hFFFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      chk("zero_rate_spike", 32'(bus.spike_o), 32'h00);
    end

    do_reset(16'd896);
    set_rates(1);
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
`ifdef POISSON_REFRACT_EN
      exp_ones = (f % 2 == 1) ? 8'h00 : 8'hFF;
`else
      exp_ones = 8'hFF;
`endif
      chk("ones_rate_spike", 32'(bus.spike_o), 32'(exp_ones));
    end

    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_rd_rand", 32'(bus.rd_rand_o), 32'd0);
    chk("midrst_vld", 32'(bus.spike_vld_o), 32'd0);
    chk("midrst_spike", 32'(bus.spike_o), 32'd0);
    chk("midrst_addr", 32'(bus.rate_addr_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    pulse_frame();
    chk("post_rst_spike", 32'(bus.spike_o), 32'hFF);

    set_rates(3);
    @(negedge clk);
    bus.start_i = 1'b1;
    last = -1;
    seen = 0;
    for (int i = 0; i < 100 && seen < 5; i++) begin
      @(negedge clk);
      if (bus.spike_vld_o) begin
        if (last >= 0) chk("vld_period", 32'(cyc - last), 32'(N + 3));
        last = cyc;
        seen++;
      end
    end
    bus.start_i = 1'b0;
    chk("held_start_frames", 32'(seen), 32'd5);

    for (int f = 0; f < 40; f++) begin
      if (f % 10 == 0) do_reset(16'($urandom_range(0, 16'hFFFE)));
      set_rates(3);
      @(negedge clk);
      bus.start_i = 1'b1;
      got = 0;
      for (int i = 0; i < 4 * N; i++) begin
        @(negedge clk);
        if (bus.spike_vld_o) begin
          got = 1;
          break;
        end
        bus.start_i = 1'($urandom_range(0, 1));
      end
      bus.start_i = 1'b0;
      chk("rand_frame_vld", 32'(got), 32'd1);
    end

    do_reset(16'd896);
    set_rates(2);
    for (int j = 0; j < N; j++) cnt[j] = 0;
    seen = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    for (int i = 0; i < 1000 * (N + 3) + 100 && seen < 1000; i++) begin
      @(negedge clk);
      if (bus.spike_vld_o) begin
        seen++;
        for (int j = 0; j < N; j++) cnt[j] += int'(bus.spike_o[j]);
      end
    end
    bus.start_i = 1'b0;
    chk("stat_frames", 32'(seen), 32'd1000);
    for (int j = 0; j < N; j++) begin
`ifdef POISSON_REFRACT_EN
      chk($sformatf("stat_ch%0d_cnt%0d", j, cnt[j]), 32'(cnt[j] >= 273 && cnt[j] <= 393), 32'd1);
`else
      chk($sformatf("stat_ch%0d_cnt%0d", j, cnt[j]), 32'(cnt[j] >= 440 && cnt[j] <= 560), 32'd1);
`endif
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/poisson_spike_encoder.md
# poisson_spike_encoder

Rate-coded input stage of the neuron tile. On each frame start it scans `NUM_CH` input channels and fetches each channel's firing rate from the rate memory. It compares each rate against a fresh pseudo-random word from the neighbouring LFSR and emits one spike bit per channel as a registered vector. It sits directly downstream of the LFSR: it drives the LFSR's read-request input and consumes its data output.

## Interface
- `DSIZE`, 16, width of rate words and random words; must match the LFSR width.
- `NUM_CH`, 8, number of input channels scanned per frame (2..256).
- `CH_AW`, 3, channel address width, equal to ceil(log2(`NUM_CH`)).

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  frame-start request; sampled only in IDLE.
- `rate_addr_o`  out  `CH_AW`  rate-memory read address.
- `rate_i`  in  `DSIZE`  rate-memory read data, valid one cycle after the address.
- `rd_rand_o`  out  1  LFSR advance request (connects to LFSR `rd_rand_i`).
- `rand_dat_i`  in  `DSIZE`  current LFSR word (connects to LFSR `lfsr_dat_o`).
- `spike_o`  out  `NUM_CH`  spike vector of the last completed frame.
- `spike_vld_o`  out  1  one-cycle pulse; `spike_o` is updated in the same cycle.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, PRIME, SCAN, DONE.
  - IDLE → PRIME when `start_i`=1.
  - PRIME → SCAN unconditionally.
  - SCAN → DONE after channel `NUM_CH`-1 is compared.
  - DONE → IDLE unconditionally.
- PRIME: drive `rate_addr_o`=0.
- SCAN, channel k:
  - `rate_i` holds the rate for channel k; `rate_addr_o`=k+1 (don't-care on the last channel).
  - Set work bit k = (`rate_i` > `rand_dat_i`), unsigned compare.
  - `rd_rand_o`=1, so the LFSR advances at the end of the cycle and every channel sees a distinct random word.
- DONE: copy the work vector to `spike_o`, pulse `spike_vld_o`.
- Rate semantics: rate 0 never fires. Rate all-ones always fires, because the XNOR LFSR never produces all-ones. Firing probability ≈ rate / 2^`DSIZE`.
- `start_i` outside IDLE is ignored; it is not queued.
- Channel counter is `CH_AW` bits and never wraps past `NUM_CH`-1.
- The work vector is cleared on entry to PRIME.

## Timing
- Reset values: state IDLE, `rate_addr_o`=0, `rd_rand_o`=0, `spike_o`=0, `spike_vld_o`=0, `busy_o`=0, channel counter 0, work vector 0.
- With `start_i` sampled high at edge t:
  - PRIME occupies cycle t+1.
  - SCAN occupies cycles t+2 .. t+1+`NUM_CH`.
  - DONE (`spike_vld_o`=1) occupies cycle t+2+`NUM_CH`.
  - Earliest next accepted `start_i` is at edge t+3+`NUM_CH`.
- `rd_rand_o` is high for exactly `NUM_CH` cycles per frame, contiguous, and only in SCAN.
- `spike_o` is stable between DONE pulses.
- Reset asserted mid-frame: all outputs return immediately to reset values. The partial frame is discarded and no `spike_vld_o` is produced.
- `rd_rand_o` is combinational from state (SCAN) only. It does not depend on `rand_dat_i`, so there is no combinational loop with the LFSR.

## Configuration
- `POISSON_REFRACT_EN` defined:
  - A channel whose bit in the current `spike_o` is 1 is forced to 0 in the next frame (one-frame refractory period).
  - `rd_rand_o` is still asserted for that channel, so the LFSR sequence stays identical to the non-refractory build.
- Not defined: no refractory masking; every channel is compared every frame.

## Structure
- Shared neuron package holds:
  - FSM state encoding (2-bit: IDLE=0, PRIME=1, SCAN=2, DONE=3).
  - Default `DSIZE` / `NUM_CH` constants, shared with the LFSR instantiation.
- Single flat module. The comparator and counter are inline, with no sub-module.
- The LFSR is instantiated by the parent tile, not inside this block.

## Test plan
- Reset mid-SCAN (assert `rst_i` at cycle t+4, `NUM_CH`=8) → all outputs 0 asynchronously, no `spike_vld_o`, next `start_i` runs a full frame.
- All rates 0x0000 → `spike_o`=0x00 every frame, `rd_rand_o` high exactly 8 cycles per frame.
- All rates 0xFFFF → `spike_o`=0xFF. With `POISSON_REFRACT_EN`, alternates 0xFF, 0x00, 0xFF.
- Rates 0x8000 on all channels with LFSR seed 896, 1000 frames → per-channel spike count 500±60. Bench model of the same LFSR matches `spike_o` bit-exactly.
- `start_i` held high continuously → `spike_vld_o` every `NUM_CH`+3=11 cycles; start pulses during busy are not queued.
- Single-cycle `start_i` at edge t → `rate_addr_o` sequence 0,1..7 starting cycle t+1, `spike_vld_o` at cycle t+10.
